wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//  Controls the register-file write-back path: selects the RUDataWrSrc source
//  (ALU=00, DataMem=01, PC+4=10) and drives the write strobe for the write-back mux.
//  Accepts one instruction descriptor at a time and drives data-memory loads over a
//  valid/ready request and response handshake.
//  Handles variable memory latency, flush and timeout, so the core is not tied to a
//  zero-latency data memory.
// PARAMETERS
//  TIMEOUT_CYC  64  max cycles in MEM_WAIT before abort (>=2)
//  CNT_W        32  width of committed-write counter
// PORTS
//  clk             in   1      core clock, rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  issue_valid     in   1      descriptor present
//  issue_ready     out  1      sequencer can accept descriptor
//  issue_kind      in   2      00 ALU, 01 LOAD, 10 LINK(JAL/JALR), 11 NOWB(store/branch)
//  issue_rd        in   5      destination register
//  flush           in   1      kill the in-flight instruction
//  mem_req_valid   out  1      load request to data memory
//  mem_req_ready   in   1      memory accepts request
//  mem_rsp_valid   in   1      load data valid on DataRd this cycle
//  RUDataWrSrc     out  2      write-back mux select
//  RUWr            out  1      register-file write enable
//  wb_rd           out  5      register-file write address
//  stall           out  1      = ~issue_ready
//  mem_err         out  1      1-cycle pulse on load timeout
//  wb_count        out  CNT_W  committed register writes, wraps
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, RUWr=0, RUDataWrSrc=00, wb_rd=0, mem_req_valid=0, mem_err=0,
//     wb_count=0, timeout counter=0.
//  Handshake:
//   - issue_ready = state in {IDLE, WB}.
//   - A descriptor is accepted when issue_valid & issue_ready; rd and kind are latched.
//  FSM (transitions on clk rising edge):
//   - IDLE/WB, accepting ALU or LINK -> WB.
//       WB cycle: RUWr=1, src=00 (ALU) or 10 (LINK). Latency 1; back-to-back at 1/cycle.
//   - IDLE/WB, accepting LOAD -> MEM_REQ.
//   - IDLE/WB, accepting NOWB -> IDLE. No write is issued.
//   - IDLE/WB, no accept -> IDLE.
//   - MEM_REQ: mem_req_valid=1, held until mem_req_ready.
//       On handshake -> MEM_WAIT; if mem_rsp_valid is also 1 that cycle -> WB (src=01).
//   - MEM_WAIT: counter increments each cycle.
//       mem_rsp_valid -> WB (src=01).
//       Counter reaches TIMEOUT_CYC-1 without a response -> ERR.
//   - ERR: mem_err=1 for 1 cycle, RUWr=0 -> IDLE.
//   - DRAIN: entered on flush from MEM_WAIT. Waits for mem_rsp_valid (discarded) or
//       timeout (mem_err pulse), then -> IDLE. issue_ready=0 in DRAIN.
//  Outside WB: RUWr=0 and RUDataWrSrc holds its last value.
//  Boundaries:
//   - rd==0: RUWr forced 0, src still driven; wb_count not incremented.
//   - flush in MEM_REQ: drop mem_req_valid -> IDLE, unless the request handshakes in that
//     same cycle (then -> DRAIN).
//   - flush in WB: suppresses that write (RUWr=0) and blocks accept for that cycle.
//     flush has no effect in IDLE.
//   - mem_rsp_valid in IDLE/WB/MEM_REQ (not handshaking): ignored.
//   - wb_count increments on each RUWr=1; it wraps modulo 2^CNT_W.
//   - rst_n asserted mid-load: immediate IDLE. Any later response is ignored.
// STRUCTURE
//  - Package wb_pkg: enums
//      wb_src_e    {WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10}
//      issue_kind_e
//      wb_state_e  {IDLE, WB, MEM_REQ, MEM_WAIT, DRAIN, ERR}
//  - Sub-module wb_timeout_ctr (clear, enable, expired), parameterised by TIMEOUT_CYC.
// TESTING
//  - Reset release; ALU rd=5, then LINK rd=1, back-to-back ->
//      RUWr=1 in 2 consecutive cycles, src 00 then 10, wb_rd 5 then 1, wb_count=2.
//  - LOAD rd=7; mem_req_ready after 2 cycles; rsp after 3 more ->
//      RUWr=1, src=01, wb_rd=7 exactly 1 cycle after rsp; stall=1 throughout.
//  - LOAD with TIMEOUT_CYC=8, no rsp ->
//      mem_err pulse 8 cycles after request handshake, no RUWr, back to IDLE.
//  - LOAD, flush in MEM_WAIT, rsp 4 cycles later, then ALU rd=3 ->
//      no write for the load; ALU write occurs; issue_ready=0 until rsp.
//  - ALU rd=0 and NOWB -> RUWr stays 0, wb_count unchanged.
//  - rst_n pulse mid MEM_WAIT ->
//      outputs at reset values asynchronously; late rsp causes no write.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back sequencer.
package wb_pkg;

    localparam int unsigned RD_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_LOAD = 2'b01,
        KIND_LINK = 2'b10,
        KIND_NOWB = 2'b11
    } issue_kind_e;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        MEM_REQ,
        MEM_WAIT,
        DRAIN,
        ERR
    } wb_state_e;

    // Write-back source for instructions that complete without memory.
    function automatic wb_src_e kind_src(issue_kind_e kind);
        return (kind == KIND_LINK) ? WB_PC4 : WB_ALU;
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Issue and data-memory handshake bundle; master is the core/memory side.
interface wb_sequencer_if;
    import wb_pkg::*;

    logic                issue_valid;
    logic                issue_ready;
    issue_kind_e         issue_kind;
    logic [RD_W-1:0]     issue_rd;
    logic                flush;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_rsp_valid;

    modport master (
        output issue_valid, issue_kind, issue_rd, flush, mem_req_ready, mem_rsp_valid,
        input  issue_ready, mem_req_valid
    );

    modport slave (
        input  issue_valid, issue_kind, issue_rd, flush, mem_req_ready, mem_rsp_valid,
        output issue_ready, mem_req_valid
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Cycle counter bounding how long a load may wait for its response.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: one descriptor at a time, loads over valid/ready with timeout.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_sequencer_if.slave     bus,
    output logic [1:0]        RUDataWrSrc,
    output logic              RUWr,
    output logic [RD_W-1:0]   wb_rd,
    output logic              stall,
    output logic              mem_err,
    output logic [CNT_W-1:0]  wb_count
);

    wb_state_e        state_q, state_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    wb_src_e          src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             req_hs;
    logic             wr_en;
    logic             tmo_en;
    logic             tmo_expired;

    // A flush during WB kills the write and refuses a new descriptor that cycle.
    assign bus.issue_ready   = (state_q == IDLE) || ((state_q == WB) && !bus.flush);
    assign bus.mem_req_valid = (state_q == MEM_REQ);
    assign accept            = bus.issue_valid && bus.issue_ready;
    assign req_hs            = bus.mem_req_valid && bus.mem_req_ready;
    assign wr_en             = (state_q == WB) && (rd_q != '0) && !bus.flush;
    assign tmo_en            = (state_q == MEM_WAIT) || (state_q == DRAIN);

    wb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!tmo_en),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    // Next-state, latched descriptor fields and commit counter.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        src_d   = src_q;
        cnt_d   = wr_en ? cnt_q + CNT_W'(1) : cnt_q;
        unique case (state_q)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept) begin
                    rd_d = bus.issue_rd;
                    case (bus.issue_kind)
                        KIND_ALU, KIND_LINK: begin
                            state_d = WB;
                            src_d   = kind_src(bus.issue_kind);
                        end
                        KIND_LOAD: state_d = MEM_REQ;
                        default:   state_d = IDLE;
                    endcase
                end
            end
            MEM_REQ: begin
                if (req_hs) begin
                    if (bus.mem_rsp_valid) begin
                        state_d = bus.flush ? IDLE : WB;
                        if (!bus.flush) begin
                            src_d = WB_MEM;
                        end
                    end else begin
                        state_d = bus.flush ? DRAIN : MEM_WAIT;
                    end
                end else if (bus.flush) begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = bus.flush ? IDLE : WB;
                    if (!bus.flush) begin
                        src_d = WB_MEM;
                    end
                end else if (tmo_expired) begin
                    state_d = ERR;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Response of a killed load is swallowed; a lost one still reports.
                if (bus.mem_rsp_valid) begin
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    state_d = ERR;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= '0;
            src_q   <= WB_ALU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RUDataWrSrc = src_q;
    assign RUWr        = wr_en;
    assign wb_rd       = rd_q;
    assign stall       = !bus.issue_ready;
    assign mem_err     = (state_q == ERR);
    assign wb_count    = cnt_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboarded bench for the write-back sequencer.
module tb_wb_sequencer;
    import wb_pkg::*;

    localparam int unsigned TMO   = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [1:0] src;
        logic [4:0] rd;
    } wr_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       RUDataWrSrc;
    logic             RUWr;
    logic [4:0]       wb_rd;
    logic             stall;
    logic             mem_err;
    logic [CNT_W-1:0] wb_count;

    int               n_chk = 0;
    int               n_pass = 0;
    wr_t              exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    wb_sequencer_if bus();

    wb_sequencer #(
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .RUDataWrSrc (RUDataWrSrc),
        .RUWr        (RUWr),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .mem_err     (mem_err),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input issue_kind_e k, input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_kind  = k;
        bus.issue_rd    = rd;
    endtask

    // Record a write the DUT owes us; rd 0 never commits.
    task automatic push_wr(input logic [1:0] src, input logic [4:0] rd);
        wr_t w;
        if (rd != 5'd0) begin
            w.src = src;
            w.rd  = rd;
            exp_q.push_back(w);
            exp_cnt = exp_cnt + CNT_W'(1);
        end
    endtask

    // Every committed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && RUWr) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(RUWr), 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_src", 32'(RUDataWrSrc), 32'(e.src));
                chk("wr_rd", 32'(wb_rd), 32'(e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        issue_kind_e k;
        logic [4:0]  r;

        bus.issue_valid   = 1'b0;
        bus.issue_kind    = KIND_NOWB;
        bus.issue_rd      = 5'd0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        rst_n             = 1'b0;
        exp_cnt           = '0;

        // Reset values
        @(negedge clk);
        chk("rst_ruwr", 32'(RUWr), 0);
        chk("rst_src", 32'(RUDataWrSrc), 0);
        chk("rst_rd", 32'(wb_rd), 0);
        chk("rst_req", 32'(bus.mem_req_valid), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_cnt", 32'(wb_count), 0);
        chk("rst_ready", 32'(bus.issue_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ALU rd5 then LINK rd1 back-to-back
        issue(KIND_ALU, 5'd5);
        push_wr(2'b00, 5'd5);
        step();
        issue(KIND_LINK, 5'd1);
        push_wr(2'b10, 5'd1);
        @(negedge clk);
        chk("t1_wr_a", 32'(RUWr), 1);
        chk("t1_ready_wb", 32'(bus.issue_ready), 1);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t1_wr_b", 32'(RUWr), 1);
        step();
        @(negedge clk);
        chk("t1_idle", 32'(RUWr), 0);
        chk("t1_cnt", 32'(wb_count), 32'(exp_cnt));
        step();

        // LOAD rd7 with slow request accept and response
        issue(KIND_LOAD, 5'd7);
        push_wr(2'b01, 5'd7);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t2_req", 32'(bus.mem_req_valid), 1);
        chk("t2_stall_req", 32'(stall), 1);
        step();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t2_stall_hs", 32'(stall), 1);
        step();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_stall_wait", 32'(stall), 1);
            chk("t2_req_drop", 32'(bus.mem_req_valid), 0);
            chk("t2_nowr", 32'(RUWr), 0);
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t2_stall_rsp", 32'(stall), 1);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t2_wr", 32'(RUWr), 1);
        chk("t2_src", 32'(RUDataWrSrc), 1);
        chk("t2_rd", 32'(wb_rd), 7);
        step();

        // ALU rd0 then NOWB: no commits, src still follows ALU
        issue(KIND_ALU, 5'd0);
        push_wr(2'b00, 5'd0);
        step();
        issue(KIND_NOWB, 5'd9);
        @(negedge clk);
        chk("t5_rd0_wr", 32'(RUWr), 0);
        chk("t5_rd0_src", 32'(RUDataWrSrc), 0);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t5_nowb_wr", 32'(RUWr), 0);
        chk("t5_ready", 32'(bus.issue_ready), 1);
        chk("t5_cnt", 32'(wb_count), 32'(exp_cnt));
        step();

        // LOAD with no response: error pulse TMO cycles after handshake
        issue(KIND_LOAD, 5'd4);
        step();
        bus.issue_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge clk);
            chk("t3_no_err", 32'(mem_err), 0);
            step();
        end
        @(negedge clk);
        chk("t3_err", 32'(mem_err), 1);
        chk("t3_err_wr", 32'(RUWr), 0);
        chk("t3_err_stall", 32'(stall), 1);
        step();
        @(negedge clk);
        chk("t3_err_pulse", 32'(mem_err), 0);
        chk("t3_idle", 32'(bus.issue_ready), 1);
        step();

        // LOAD flushed in MEM_WAIT, late response drained, then ALU rd3
        issue(KIND_LOAD, 5'd6);
        step();
        bus.issue_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        @(negedge clk);
        chk("t4_ready_wait", 32'(bus.issue_ready), 0);
        step();
        bus.flush = 1'b0;
        issue(KIND_ALU, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_drain_ready", 32'(bus.issue_ready), 0);
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t4_drain_rsp_ready", 32'(bus.issue_ready), 0);
        chk("t4_drain_err", 32'(mem_err), 0);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle_ready", 32'(bus.issue_ready), 1);
        chk("t4_nowr", 32'(RUWr), 0);
        push_wr(2'b00, 5'd3);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t4_alu_wr", 32'(RUWr), 1);
        step();

        // Flush during WB kills the write and blocks the offered LINK
        issue(KIND_ALU, 5'd9);
        step();
        bus.flush = 1'b1;
        issue(KIND_LINK, 5'd2);
        @(negedge clk);
        chk("t6_flush_wr", 32'(RUWr), 0);
        step();
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t6_blocked", 32'(RUWr), 0);
        chk("t6_cnt", 32'(wb_count), 32'(exp_cnt));
        step();

        // Flush in MEM_REQ without handshake, stray response ignored
        issue(KIND_LOAD, 5'd11);
        step();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b1;
        @(negedge clk);
        chk("t7_req", 32'(bus.mem_req_valid), 1);
        step();
        bus.flush         = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t7_req_drop", 32'(bus.mem_req_valid), 0);
        chk("t7_ready", 32'(bus.issue_ready), 1);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t7_nowr", 32'(RUWr), 0);
        step();

        // Random back-to-back ALU/LINK stream, wraps the commit counter
        for (int i = 0; i < 20; i++) begin
            k = ($urandom_range(0, 1) == 0) ? KIND_ALU : KIND_LINK;
            r = 5'($urandom_range(1, 31));
            issue(k, r);
            push_wr((k == KIND_LINK) ? 2'b10 : 2'b00, r);
            step();
        end
        bus.issue_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t8_wrap_cnt", 32'(wb_count), 32'(exp_cnt));
        step();

        // Asynchronous reset mid MEM_WAIT, late response ignored
        issue(KIND_LOAD, 5'd12);
        step();
        bus.issue_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("t9_wait_stall", 32'(stall), 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t9_rst_ready", 32'(bus.issue_ready), 1);
        chk("t9_rst_cnt", 32'(wb_count), 0);
        chk("t9_rst_rd", 32'(wb_rd), 0);
        chk("t9_rst_src", 32'(RUDataWrSrc), 0);
        chk("t9_rst_req", 32'(bus.mem_req_valid), 0);
        chk("t9_rst_ruwr", 32'(RUWr), 0);
        exp_cnt = '0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("t9_late_rsp_wr", 32'(RUWr), 0);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t9_after_wr", 32'(RUWr), 0);
        chk("t9_after_cnt", 32'(wb_count), 0);
        chk("t9_after_ready", 32'(bus.issue_ready), 1);

        chk("q_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
